// File: rtl/l2_backing_memory.sv
// Block-granular main memory behind the L2 cache: fixed-latency block reads
// and write-through block commits in the cycle they are presented.
// Ports:
//   clk, rst_n       clock, async active-low reset
//   mem_addr         byte address (offset bits ignored)
//   mem_data_out     write block from L2
//   mem_read         read request, level, held until mem_ready
//   mem_write        single-cycle write strobe
//   mem_data_block   read block, zero unless mem_ready
//   mem_ready        one-cycle read-complete pulse
//   busy             FSM not idle
//   rd_count         completed reads, saturating
//   wr_count         committed writes, saturating
module l2_backing_memory #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 11,
    parameter int BLOCK_SIZE   = 32,
    parameter int READ_LATENCY = 4,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [ADDR_WIDTH-1:0]            mem_addr,
    input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_data_out,
    input  logic                             mem_read,
    input  logic                             mem_write,
    output logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_data_block,
    output logic                             mem_ready,
    output logic                             busy,
    output logic [CNT_WIDTH-1:0]             rd_count,
    output logic [CNT_WIDTH-1:0]             wr_count
);

    localparam int OFFSET_WIDTH = $clog2(BLOCK_SIZE);
    localparam int IDX_WIDTH    = ADDR_WIDTH - OFFSET_WIDTH;
    localparam int NUM_BLOCKS   = 2 ** IDX_WIDTH;
    localparam int BLK_W        = BLOCK_SIZE * DATA_WIDTH;
    localparam logic [7:0] LAT_INIT = 8'(READ_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP,
        S_REARM
    } state_t;

    state_t                 state_q, state_d;
    logic [7:0]             lat_cnt_q, lat_cnt_d;
    logic [IDX_WIDTH-1:0]   idx_q, idx_d;
    logic                   ready_q, ready_d;
    logic [BLK_W-1:0]       data_q, data_d;
    logic [CNT_WIDTH-1:0]   rd_cnt_q, rd_cnt_d;
    logic [CNT_WIDTH-1:0]   wr_cnt_q, wr_cnt_d;
    logic [BLK_W-1:0]       mem_q [NUM_BLOCKS];

    logic [IDX_WIDTH-1:0]   addr_idx;
    logic                   unused_offset;

    assign addr_idx      = mem_addr[ADDR_WIDTH-1:OFFSET_WIDTH];
    assign unused_offset = ^mem_addr[OFFSET_WIDTH-1:0];

    // RESP is the cycle before the response: the output register loads
    // the block at the end of it, so mem_ready appears READ_LATENCY
    // cycles after acceptance and sees every write up to that edge.
    always_comb begin
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        idx_d     = idx_q;
        unique case (state_q)
            S_IDLE: begin
                if (mem_read) begin
                    idx_d     = addr_idx;
                    lat_cnt_d = LAT_INIT;
                    state_d   = (READ_LATENCY == 1) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!mem_read) begin
                    state_d = S_IDLE;
                end else begin
                    lat_cnt_d = lat_cnt_q - 8'd1;
                    if (lat_cnt_q == 8'd1) begin
                        state_d = S_RESP;
                    end
                end
            end
            S_RESP: begin
                state_d = S_REARM;
            end
            S_REARM: begin
                // L2 keeps mem_read high one cycle past mem_ready.
                if (!mem_read) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        ready_d  = (state_q == S_RESP);
        data_d   = ready_d ? mem_q[idx_q] : '0;
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (ready_d && (rd_cnt_q != '1)) begin
            rd_cnt_d = rd_cnt_q + 1'b1;
        end
        if (mem_write && (wr_cnt_q != '1)) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            lat_cnt_q <= '0;
            idx_q     <= '0;
            ready_q   <= 1'b0;
            data_q    <= '0;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            lat_cnt_q <= lat_cnt_d;
            idx_q     <= idx_d;
            ready_q   <= ready_d;
            data_q    <= data_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BLOCKS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_write) begin
            mem_q[addr_idx] <= mem_data_out;
        end
    end

    assign mem_ready      = ready_q;
    assign mem_data_block = data_q;
    assign busy           = (state_q != S_IDLE);
    assign rd_count       = rd_cnt_q;
    assign wr_count       = wr_cnt_q;

endmodule
